// File: rtl/common_types_pkg.sv
// Types and small helpers shared by the core's memory-side blocks.
// The arbiter FSM encoding lives here so other blocks can decode it.
package common_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

  function automatic logic data_req(input logic dren, input logic [3:0] dwen);
    return dren | (|dwen);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access.
// Data wins arbitration until MAX_D_STREAK grants starve a pending fetch.
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          ram_ren_q, ram_ren_d;
  logic [3:0]    ram_wen_q, ram_wen_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;

  logic d_req_s, grant_i_s, grant_d_s, d_match_s, ihit_s, dhit_s;

  // Arbitration, completion check and next-state for the access sequencer.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ihit_s      = 1'b0;
    dhit_s      = 1'b0;

    d_req_s   = data_req(dren, dwen);
    grant_i_s = iren & (~d_req_s | (streak_q == STREAK_MAX));
    grant_d_s = d_req_s & ~grant_i_s;
    // A data completion only counts if the same kind of access is still asked for.
    d_match_s = (daddr == ram_addr_q) & (ram_ren_q ? (dren & ~(|dwen)) : (|dwen));

    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          state_d    = ISERV;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 4'b0000;
          ram_addr_d = iaddr;
          streak_d   = {SW{1'b0}};
        end else if (grant_d_s) begin
          state_d     = DSERV;
          ram_ren_d   = dren & ~(|dwen);
          ram_wen_d   = dwen;
          ram_addr_d  = daddr;
          ram_wdata_d = dstore;
          if (!iren) begin
            streak_d = {SW{1'b0}};
          end else if (streak_q == STREAK_MAX) begin
            streak_d = streak_q;
          end else begin
            streak_d = streak_q + SW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISERV: begin
        if (ram_ready) begin
          ihit_s    = iren & (iaddr == ram_addr_q);
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 4'b0000;
        end else begin
          state_d = ISERV;
        end
      end
      DSERV: begin
        // The RAM cannot abort a write, so the access always runs to ready.
        if (ram_ready) begin
          dhit_s    = d_match_s;
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 4'b0000;
        end else begin
          state_d = DSERV;
        end
      end
      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 4'b0000;
      end
    endcase
  end

  // State, streak and RAM strobe registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      streak_q    <= {SW{1'b0}};
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 4'b0000;
      ram_addr_q  <= 32'h0000_0000;
      ram_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  assign iwait = ~ihit_s;
  assign iload = ihit_s ? ram_rdata : 32'h0000_0000;
  assign dwait = d_req_s & ~dhit_s;
  assign dload = (dhit_s & ram_ren_q) ? ram_rdata : 32'h0000_0000;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one single-port RAM between the core's instruction-fetch and data-access channels. It sits between the datapath's `cpu_ram_if.cpu` side and the memory model or controller. Each access is sequenced through a small FSM that holds the RAM request until the RAM accepts it. The block drives `iwait` and `dwait` back to the core, which the hazard unit consumes as `~ihit` and `~dhit`.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while a fetch is pending, before the fetch is forced through. Legal range ≥1.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `iren`  in  1  instruction read request.
- `iaddr`  in  32  instruction address.
- `iwait`  out  1  instruction access not complete this cycle.
- `iload`  out  32  fetched instruction. Valid only when `iren & ~iwait`.
- `dren`  in  1  data read request.
- `dwen`  in  4  data byte write enables. Any bit set means a write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  write data, already lane-aligned.
- `dwait`  out  1  data access not complete this cycle.
- `dload`  out  32  read data. Valid only when a data read completes (`dren & ~dwait`).
- `ram_ren`  out  1  RAM read strobe.
- `ram_wen`  out  4  RAM byte write strobes.
- `ram_addr`  out  32  RAM address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data. Valid when `ram_ready`.
- `ram_ready`  in  1  one-cycle pulse: current RAM access is done.

## Operation
- The FSM has three states: IDLE, ISERV (instruction access in flight) and DSERV (data access in flight).
- **IDLE arbitration:**
  - Data request (`dren | |dwen`) beats instruction request, unless `streak == MAX_D_STREAK` and `iren` is also pending. In that case the instruction wins.
  - No request: stay in IDLE.
- **Grant:**
  - The granted address is latched into `ram_addr`.
  - For data, `dwen` and `dstore` are also latched. `ram_ren` is latched as `dren & ~|dwen`; a write overrides a simultaneous read.
  - For instruction, `ram_ren` is latched to 1 and `ram_wen` to 0.
- **SERV states:**
  - The RAM strobes stay registered and stable until `ram_ready`.
  - On `ram_ready`, the strobes clear and the FSM returns to IDLE. There is no direct SERV→SERV transition.
- **Completion check in ISERV:**
  - At `ram_ready`, the access is a hit only if `iren` is set and `iaddr` equals the latched address.
  - On a hit: `iwait=0` and `iload=ram_rdata` that cycle.
  - On a mismatch (PC redirected mid-access): the result is discarded, `iwait` stays 1, and the FSM goes to IDLE and re-arbitrates.
- **Completion check in DSERV:**
  - The same check applies with `daddr` and request type.
  - A write always completes in the RAM even if the request was withdrawn, because the RAM cannot abort.
  - `dwait=0` only if the request still matches.
- **Output defaults:**
  - `iwait = ~ihit`, where ihit is asserted only on an instruction hit.
  - `dwait = (dren | |dwen) & ~dhit`.
  - `iload` and `dload` are 0 in every cycle that is not their own hit.
- **Streak counter** (width `$clog2(MAX_D_STREAK+1)`):
  - Increments on a data grant made while `iren` is set, saturating at `MAX_D_STREAK`.
  - Clears on an instruction grant, and on any data grant made with `iren` low.

## Timing
- **Reset values:** state IDLE, `streak=0`, `ram_ren=0`, `ram_wen=0`, `ram_addr=0`, `ram_wdata=0`, `iwait=1`, `iload=0`, `dload=0`. `dwait` follows its equation, so it is 0 when there is no data request.
- **Latency:**
  - Request sampled in IDLE at cycle N; RAM strobes are high from N+1.
  - With `ram_ready` at N+1 (zero-wait RAM), the hit is at N+1 and the FSM is back in IDLE at N+2.
  - Peak throughput is therefore one access per 2 cycles. Each RAM wait state adds 1 cycle.
- **Combinational paths:** `iwait`/`dwait`/`iload`/`dload` are combinational from `ram_ready`, `ram_rdata`, the request inputs and the registered state. There is no combinational path from the request inputs to the RAM strobes.
- **Ignored inputs:** `ram_ready` is ignored in IDLE.
- **Reset mid-access:** the FSM drops to IDLE asynchronously and the strobes deassert immediately. The RAM is reset by the same `nrst`.
- **Simultaneous `iren` and data request with streak saturated:** the instruction is granted and the streak clears in the same cycle.

## Structure
- `arb_state_t` enum (IDLE, ISERV, DSERV) goes in `common_types_pkg`.
- No sub-module is needed. The FSM, latches, streak counter and hit compare all live in one module.
- A `ram_arbiter_if` modport pair is optional. The port list above is normative.

## Test plan
- **Zero-wait fetch stream:** `iren=1`, `iaddr=0x0`, RAM returns `ram_ready` the cycle after its strobe with `ram_rdata=0x00000013` → `iwait` low every 2nd cycle and `iload=0x00000013` in those cycles.
- **Data priority:**
  - Stimulus: `dwen=4'b1111`, `daddr=0x100`, `dstore=0xDEADBEEF` with `iren=1` pending.
  - Required response: write granted first with `ram_wen=4'b1111`, `ram_wdata=0xDEADBEEF`; instruction granted next.
- **Starvation limit:** `dren` held high continuously with `MAX_D_STREAK=4` → exactly 4 data grants, then 1 instruction grant, then the data grants repeat.
- **Redirect:**
  - Stimulus: `iaddr` changes from `0x40` to `0x80` while ISERV waits 3 cycles for `ram_ready`.
  - Required response: no hit for `0x40`, then a new ISERV with `ram_addr=0x80` and a hit with the correct data.
- **Reset mid-DSERV:** `nrst` pulsed low during a pending write → `ram_wen=0` immediately, state IDLE, all outputs at reset values.
- **Wait states:** RAM delays `ram_ready` by 5 cycles on a byte write (`dwen=4'b0100`) → `dwait=1` for 5 cycles, `ram_wen` stable at `4'b0100` throughout, `dwait=0` on the ready cycle.
